// File: rtl/rename_pkg.sv
// Shared defaults and slicing helper for the rename bypass pipeline.
package rename_pkg;

    localparam int PREG_W_DEFAULT   = 7;
    localparam int AREG_W_DEFAULT   = 5;
    localparam int ZERO_REG_DEFAULT = 31;

    // LSB position of lane `lane` inside a flat per-lane bus of `field_w`-bit fields.
    function automatic int lane_lsb(input int lane, input int field_w);
        return lane * field_w;
    endfunction

endpackage

// File: rtl/rename_bypass_pipe_dep_sel.sv
// Youngest-older-producer select for one source of one rename lane.
module rename_dep_sel
    import rename_pkg::*;
#(
    parameter int N_OLDER  = 1,
    parameter int PREG_W   = PREG_W_DEFAULT,
    parameter int AREG_W   = AREG_W_DEFAULT,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic [AREG_W-1:0]         src_arch,
    input  logic [PREG_W-1:0]         rat_phys,
    input  logic [N_OLDER-1:0]        prod_en,
    input  logic [N_OLDER*AREG_W-1:0] prod_arch,
    input  logic [N_OLDER*PREG_W-1:0] prod_phys,
    output logic [PREG_W-1:0]         sel_phys
);

    localparam logic [AREG_W-1:0] ZERO_ARCH = AREG_W'(ZERO_REG);

    // Scanning oldest to youngest lets the youngest matching producer win.
    always_comb begin
        sel_phys = rat_phys;
        for (int i = 0; i < N_OLDER; i++) begin
            if (prod_en[i] && (src_arch != ZERO_ARCH) &&
                (prod_arch[lane_lsb(i, AREG_W) +: AREG_W] == src_arch)) begin
                sel_phys = prod_phys[lane_lsb(i, PREG_W) +: PREG_W];
            end
        end
    end

endmodule

// File: rtl/rename_bypass_pipe.sv
// Rename group bypass: resolves intra-group dependencies and registers the group
// behind a single-entry valid/ready output stage.
module rename_bypass_pipe
    import rename_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PREG_W   = PREG_W_DEFAULT,
    parameter int AREG_W   = AREG_W_DEFAULT,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [WIDTH-1:0]        lane_valid_i,
    input  logic [WIDTH-1:0]        lane_wr_i,
    input  logic [WIDTH*AREG_W-1:0] rs1_arch_i,
    input  logic [WIDTH*AREG_W-1:0] rs2_arch_i,
    input  logic [WIDTH*AREG_W-1:0] rd_arch_i,
    input  logic [WIDTH*PREG_W-1:0] rs1_phys_i,
    input  logic [WIDTH*PREG_W-1:0] rs2_phys_i,
    input  logic [WIDTH*PREG_W-1:0] oldrd_phys_i,
    input  logic [WIDTH*PREG_W-1:0] newrd_phys_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        lane_valid_o,
    output logic [WIDTH*PREG_W-1:0] rs1_phys_o,
    output logic [WIDTH*PREG_W-1:0] rs2_phys_o,
    output logic [WIDTH*PREG_W-1:0] rd_phys_o,
    output logic [WIDTH*PREG_W-1:0] oldrd_phys_o
);

    logic [WIDTH-1:0]        prod_en;
    logic [WIDTH*PREG_W-1:0] rs1_res, rs2_res, oldrd_res;
    logic                    load, drain;
    logic                    unused_bits;

    // Only present, writing lanes may forward their new tag to younger lanes.
    assign prod_en     = lane_valid_i & lane_wr_i;
    assign unused_bits = ^{prod_en[WIDTH-1], rs1_arch_i[AREG_W-1:0], rs2_arch_i[AREG_W-1:0]};

    for (genvar j = 0; j < WIDTH; j++) begin : g_lane
        if (j == 0) begin : g_head
            assign rs1_res[0 +: PREG_W]   = rs1_phys_i[0 +: PREG_W];
            assign rs2_res[0 +: PREG_W]   = rs2_phys_i[0 +: PREG_W];
            assign oldrd_res[0 +: PREG_W] = oldrd_phys_i[0 +: PREG_W];
        end else begin : g_dep
            rename_dep_sel #(.N_OLDER(j), .PREG_W(PREG_W), .AREG_W(AREG_W), .ZERO_REG(ZERO_REG)) u_rs1 (
                .src_arch (rs1_arch_i[j*AREG_W +: AREG_W]),
                .rat_phys (rs1_phys_i[j*PREG_W +: PREG_W]),
                .prod_en  (prod_en[j-1:0]),
                .prod_arch(rd_arch_i[j*AREG_W-1:0]),
                .prod_phys(newrd_phys_i[j*PREG_W-1:0]),
                .sel_phys (rs1_res[j*PREG_W +: PREG_W])
            );
            rename_dep_sel #(.N_OLDER(j), .PREG_W(PREG_W), .AREG_W(AREG_W), .ZERO_REG(ZERO_REG)) u_rs2 (
                .src_arch (rs2_arch_i[j*AREG_W +: AREG_W]),
                .rat_phys (rs2_phys_i[j*PREG_W +: PREG_W]),
                .prod_en  (prod_en[j-1:0]),
                .prod_arch(rd_arch_i[j*AREG_W-1:0]),
                .prod_phys(newrd_phys_i[j*PREG_W-1:0]),
                .sel_phys (rs2_res[j*PREG_W +: PREG_W])
            );
            rename_dep_sel #(.N_OLDER(j), .PREG_W(PREG_W), .AREG_W(AREG_W), .ZERO_REG(ZERO_REG)) u_oldrd (
                .src_arch (rd_arch_i[j*AREG_W +: AREG_W]),
                .rat_phys (oldrd_phys_i[j*PREG_W +: PREG_W]),
                .prod_en  (prod_en[j-1:0]),
                .prod_arch(rd_arch_i[j*AREG_W-1:0]),
                .prod_phys(newrd_phys_i[j*PREG_W-1:0]),
                .sel_phys (oldrd_res[j*PREG_W +: PREG_W])
            );
        end
    end

    // ---- stage p1: registered output group ----
    logic                    vld_p1;
    logic [WIDTH-1:0]        lane_vld_p1;
    logic [WIDTH*PREG_W-1:0] rs1_p1, rs2_p1, rd_p1, oldrd_p1;

    assign in_ready_o = rst_i || !vld_p1 || out_ready_i;
    assign load       = in_valid_i && in_ready_o && !flush_i;
    assign drain      = vld_p1 && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1      <= 1'b0;
            lane_vld_p1 <= '0;
        end else if (flush_i) begin
            vld_p1      <= 1'b0;
            lane_vld_p1 <= '0;
        end else if (load) begin
            vld_p1      <= 1'b1;
            lane_vld_p1 <= lane_valid_i;
        end else if (drain) begin
            vld_p1      <= 1'b0;
            lane_vld_p1 <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs1_p1   <= '0;
            rs2_p1   <= '0;
            rd_p1    <= '0;
            oldrd_p1 <= '0;
        end else if (load) begin
            rs1_p1   <= rs1_res;
            rs2_p1   <= rs2_res;
            rd_p1    <= newrd_phys_i;
            oldrd_p1 <= oldrd_res;
        end
    end

    assign out_valid_o  = vld_p1;
    assign lane_valid_o = lane_vld_p1;
    assign rs1_phys_o   = rs1_p1;
    assign rs2_phys_o   = rs2_p1;
    assign rd_phys_o    = rd_p1;
    assign oldrd_phys_o = oldrd_p1;

endmodule

// File: tb/tb_rename_bypass_pipe.sv
// Self-checking bench for rename_bypass_pipe: directed dependency cases,
// stall/flush/reset handshaking, and randomized traffic against a reference model.
module tb_rename_bypass_pipe;

    localparam int W  = 4;
    localparam int P  = 7;
    localparam int A  = 5;
    localparam int ZR = 31;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   lane_valid = '0, lane_wr = '0;
    logic [W*A-1:0] rs1_arch = '0, rs2_arch = '0, rd_arch = '0;
    logic [W*P-1:0] rs1_rat = '0, rs2_rat = '0, oldrd_rat = '0, newrd = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   lane_valid_q;
    logic [W*P-1:0] rs1_o, rs2_o, rd_o, oldrd_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rename_bypass_pipe #(.WIDTH(W), .PREG_W(P), .AREG_W(A), .ZERO_REG(ZR)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .lane_valid_i(lane_valid), .lane_wr_i(lane_wr),
        .rs1_arch_i(rs1_arch), .rs2_arch_i(rs2_arch), .rd_arch_i(rd_arch),
        .rs1_phys_i(rs1_rat), .rs2_phys_i(rs2_rat), .oldrd_phys_i(oldrd_rat),
        .newrd_phys_i(newrd),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .lane_valid_o(lane_valid_q),
        .rs1_phys_o(rs1_o), .rs2_phys_o(rs2_o), .rd_phys_o(rd_o), .oldrd_phys_o(oldrd_o)
    );

    // Reference: a source looks up the most recent in-group writer before its lane.
    function automatic logic [P-1:0] lookup(input int lane, input logic [A-1:0] key,
                                            input logic [P-1:0] rat);
        logic [P-1:0] r;
        r = rat;
        if (key != A'(ZR))
            for (int i = lane - 1; i >= 0; i--)
                if (lane_valid[i] && lane_wr[i] && rd_arch[i*A +: A] == key) begin
                    r = newrd[i*P +: P];
                    break;
                end
        return r;
    endfunction

    task automatic model(output logic [W*P-1:0] e1, output logic [W*P-1:0] e2,
                         output logic [W*P-1:0] eo);
        for (int j = 0; j < W; j++) begin
            e1[j*P +: P] = lookup(j, rs1_arch[j*A +: A], rs1_rat[j*P +: P]);
            e2[j*P +: P] = lookup(j, rs2_arch[j*A +: A], rs2_rat[j*P +: P]);
            eo[j*P +: P] = lookup(j, rd_arch[j*A +: A], oldrd_rat[j*P +: P]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_group();
        lane_valid = '0; lane_wr = '0;
        rs1_arch = '0; rs2_arch = '0; rd_arch = '0;
        rs1_rat = '0; rs2_rat = '0; oldrd_rat = '0; newrd = '0;
    endtask

    task automatic random_group();
        lane_valid = W'($urandom); lane_wr = W'($urandom);
        for (int j = 0; j < W; j++) begin
            rs1_arch[j*A +: A] = ($urandom_range(0, 9) == 0) ? A'(ZR) : A'($urandom_range(0, 5));
            rs2_arch[j*A +: A] = ($urandom_range(0, 9) == 0) ? A'(ZR) : A'($urandom_range(0, 5));
            rd_arch[j*A +: A]  = ($urandom_range(0, 9) == 0) ? A'(ZR) : A'($urandom_range(0, 5));
        end
        rs1_rat = (W*P)'({$urandom, $urandom}); rs2_rat = (W*P)'({$urandom, $urandom});
        oldrd_rat = (W*P)'({$urandom, $urandom}); newrd = (W*P)'({$urandom, $urandom});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        tests++;
        if (out_valid !== 1'b0 || lane_valid_q !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ctrl: out_valid=%b lane_valid=%b in_ready=%b, want 0 0000 1",
                     out_valid, lane_valid_q, in_ready);
        end
        tests++;
        if (rs1_o !== '0 || rs2_o !== '0 || rd_o !== '0 || oldrd_o !== '0) begin
            fails++;
            $display("FAIL reset_tags: rs1=%h rs2=%h rd=%h oldrd=%h, want all 0",
                     rs1_o, rs2_o, rd_o, oldrd_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_bypass();
        clear_group();
        lane_valid = 4'b0011; lane_wr = 4'b0001;
        rd_arch[0*A +: A] = 5'd3; rs1_arch[1*A +: A] = 5'd3;
        newrd[0*P +: P] = 7'h45; rs1_rat[1*P +: P] = 7'h0A;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || rs1_o[1*P +: P] !== 7'h45) begin
            fails++;
            $display("FAIL single_bypass: out_valid=%b rs1[1]=%h, want 1 45", out_valid, rs1_o[1*P +: P]);
        end
    endtask

    task automatic test_chain();
        clear_group();
        lane_valid = 4'b1111; lane_wr = 4'b0111;
        rd_arch[0*A +: A] = 5'd7; rd_arch[1*A +: A] = 5'd7; rd_arch[2*A +: A] = 5'd7; rd_arch[3*A +: A] = 5'd1;
        newrd[0*P +: P] = 7'h10; newrd[1*P +: P] = 7'h11; newrd[2*P +: P] = 7'h12; newrd[3*P +: P] = 7'h13;
        rs2_arch[3*A +: A] = 5'd7; rs2_rat[3*P +: P] = 7'h55;
        oldrd_rat = {7'h33, 7'h32, 7'h31, 7'h30};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (rs2_o[3*P +: P] !== 7'h12 || oldrd_o[2*P +: P] !== 7'h11 || oldrd_o[1*P +: P] !== 7'h10) begin
            fails++;
            $display("FAIL chain: rs2[3]=%h oldrd[2]=%h oldrd[1]=%h, want 12 11 10",
                     rs2_o[3*P +: P], oldrd_o[2*P +: P], oldrd_o[1*P +: P]);
        end
        tests++;
        if (oldrd_o[0*P +: P] !== 7'h30 || oldrd_o[3*P +: P] !== 7'h33 || rd_o !== newrd) begin
            fails++;
            $display("FAIL chain_rat: oldrd=%h rd=%h, want oldrd lanes 0/3 = 30/33 rd=%h",
                     oldrd_o, rd_o, newrd);
        end
    endtask

    task automatic test_zero_and_invalid();
        clear_group();
        lane_valid = 4'b0101; lane_wr = 4'b0001;
        rd_arch[0*A +: A] = 5'd31; rs1_arch[2*A +: A] = 5'd31;
        newrd[0*P +: P] = 7'h50; rs1_rat[2*P +: P] = 7'h1F;
        in_valid = 1'b1;
        step();
        tests++;
        if (rs1_o[2*P +: P] !== 7'h1F) begin
            fails++;
            $display("FAIL zero_reg: rs1[2]=%h, want 1f", rs1_o[2*P +: P]);
        end
        clear_group();
        lane_valid = 4'b0010; lane_wr = 4'b0001;
        rd_arch[0*A +: A] = 5'd4; rs1_arch[1*A +: A] = 5'd4;
        newrd[0*P +: P] = 7'h60; rs1_rat[1*P +: P] = 7'h22;
        step();
        in_valid = 1'b0;
        tests++;
        if (rs1_o[1*P +: P] !== 7'h22 || lane_valid_q !== 4'b0010) begin
            fails++;
            $display("FAIL invalid_producer: rs1[1]=%h lane_valid=%b, want 22 0010",
                     rs1_o[1*P +: P], lane_valid_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [W*P-1:0] a1, a2, ao, ard, b1, b2, bo, brd;
        logic [W-1:0]   alv, blv;
        random_group(); lane_valid = 4'b1011;
        model(a1, a2, ao); ard = newrd; alv = lane_valid;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        random_group(); lane_valid = 4'b0111;
        model(b1, b2, bo); brd = newrd; blv = lane_valid;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_ready: cycle %0d in_ready=%b, want 0", c, in_ready);
            end
            step();
            tests++;
            if (out_valid !== 1'b1 || lane_valid_q !== alv || rs1_o !== a1 || rs2_o !== a2 ||
                oldrd_o !== ao || rd_o !== ard) begin
                fails++;
                $display("FAIL stall_hold: cycle %0d valid=%b lv=%b rs1=%h rs2=%h, want 1 %b %h %h",
                         c, out_valid, lane_valid_q, rs1_o, rs2_o, alv, a1, a2);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_ready: in_ready=%b, want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || lane_valid_q !== blv || rs1_o !== b1 || rs2_o !== b2 ||
            oldrd_o !== bo || rd_o !== brd) begin
            fails++;
            $display("FAIL back_to_back: valid=%b lv=%b rs1=%h oldrd=%h, want 1 %b %h %h",
                     out_valid, lane_valid_q, rs1_o, oldrd_o, blv, b1, bo);
        end
    endtask

    task automatic test_flush_and_reset();
        random_group(); lane_valid = 4'b1111;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || lane_valid_q !== '0) begin
            fails++;
            $display("FAIL flush: out_valid=%b lane_valid=%b, want 0 0000", out_valid, lane_valid_q);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop: out_valid=%b, want 0", out_valid);
        end
        random_group(); lane_valid = 4'b1111;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_during: in_ready=%b, want 1", in_ready);
        end
        step();
        rst = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || lane_valid_q !== '0 || in_ready !== 1'b1 || rs1_o !== '0) begin
            fails++;
            $display("FAIL reset_mid_stall: valid=%b lv=%b in_ready=%b rs1=%h, want 0 0000 1 0",
                     out_valid, lane_valid_q, in_ready, rs1_o);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        logic           mvld;
        logic [W-1:0]   mlv;
        logic [W*P-1:0] m1, m2, mo, mrd, t1, t2, to;
        logic           exp_rdy, bad;
        mvld = 1'b0; mlv = '0; m1 = '0; m2 = '0; mo = '0; mrd = '0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            random_group();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            exp_rdy = !mvld || out_ready;
            tests++;
            if (in_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rand_ready: cycle %0d in_ready=%b, want %b", c, in_ready, exp_rdy);
            end
            model(t1, t2, to);
            if (flush) begin
                mvld = 1'b0;
            end else if (in_valid && exp_rdy) begin
                mvld = 1'b1; mlv = lane_valid; m1 = t1; m2 = t2; mo = to; mrd = newrd;
            end else if (mvld && out_ready) begin
                mvld = 1'b0;
            end
            step();
            tests++;
            if (out_valid !== mvld) begin
                fails++;
                $display("FAIL rand_valid: cycle %0d out_valid=%b, want %b", c, out_valid, mvld);
            end
            if (mvld) begin
                bad = (lane_valid_q !== mlv);
                for (int j = 0; j < W; j++)
                    if (mlv[j] && (rs1_o[j*P +: P] !== m1[j*P +: P] || rs2_o[j*P +: P] !== m2[j*P +: P] ||
                                   oldrd_o[j*P +: P] !== mo[j*P +: P] || rd_o[j*P +: P] !== mrd[j*P +: P]))
                        bad = 1'b1;
                tests++;
                if (bad) begin
                    fails++;
                    $display("FAIL rand_data: cycle %0d lv=%b rs1=%h rs2=%h oldrd=%h rd=%h, want %b %h %h %h %h",
                             c, lane_valid_q, rs1_o, rs2_o, oldrd_o, rd_o, mlv, m1, m2, mo, mrd);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_bypass();
        test_chain();
        test_zero_and_invalid();
        test_back_to_back();
        test_flush_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rename_bypass_pipe.md
RENAME_BYPASS_PIPE -- requirements
Module: rename_bypass_pipe

Interface
REQ-001 Parameter WIDTH, default 4: rename lanes per group.
REQ-002 Parameter PREG_W, default 7: physical register tag width.
REQ-003 Parameter AREG_W, default 5: architectural register index width.
REQ-004 Parameter ZERO_REG, default 31: architectural zero register; never a dependency source or target.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 flush_i  in  1  kill the registered group and any group offered this cycle.
REQ-008 in_valid_i  in  1  group offered; in_ready_o  out  1  group accepted.
REQ-009 lane_valid_i  in  WIDTH  per-lane instruction present.
REQ-010 lane_wr_i  in  WIDTH  per-lane destination write enable.
REQ-011 rs1_arch_i, rs2_arch_i, rd_arch_i  in  WIDTH*AREG_W  architectural indices, lane k at bits [k*AREG_W +: AREG_W].
REQ-012 rs1_phys_i, rs2_phys_i, oldrd_phys_i  in  WIDTH*PREG_W  RAT lookup results per lane.
REQ-013 newrd_phys_i  in  WIDTH*PREG_W  free-list tags allocated per lane.
REQ-014 out_valid_o  out  1  registered group valid; out_ready_i  in  1  downstream accepts.
REQ-015 lane_valid_o  out  WIDTH  registered lane mask.
REQ-016 rs1_phys_o, rs2_phys_o, rd_phys_o, oldrd_phys_o  out  WIDTH*PREG_W  resolved tags, same packing.

Function
REQ-017 Dependency rule: source s of lane j SHALL take newrd_phys_i of the youngest lane i<j with lane_valid_i[i], lane_wr_i[i], rd_arch[i]==s arch, s arch!=ZERO_REG; else its RAT value.
REQ-018 oldrd of lane j SHALL use the same rule keyed on rd_arch[j], so it returns the previous in-group mapping when one exists.
REQ-019 Lane 0 SHALL always use RAT values; rd_phys_o SHALL equal newrd_phys_i unchanged.
REQ-020 Lanes with lane_valid_i=0 SHALL never act as producers; their outputs are don't-care but lane_valid_o=0.
REQ-021 in_ready_o SHALL equal !out_valid_o || out_ready_i (combinational, no dependency on in_valid_i).
REQ-022 Transfer in when in_valid_i && in_ready_o && !flush_i; resolved group SHALL appear on outputs next cycle (latency 1).
REQ-023 Transfer out when out_valid_o && out_ready_i; out_valid_o falls unless a new group loads the same cycle.
REQ-024 Simultaneous out-transfer and in-transfer SHALL keep out_valid_o=1 with the new group (full throughput, one group per cycle).
REQ-025 While out_valid_o && !out_ready_i, all output registers SHALL hold stable.
REQ-026 flush_i SHALL clear out_valid_o and lane_valid_o next cycle regardless of out_ready_i or in_valid_i; flush dominates load.
REQ-027 Data registers SHALL load only on in-transfer.

Reset
REQ-028 On rst_i, out_valid_o=0 and lane_valid_o=0 on the following edge; tag outputs SHALL reset to 0.
REQ-029 in_ready_o SHALL be 1 during and after reset.
REQ-030 Reset SHALL take priority over flush_i and in-transfer in the same cycle.

Structure
REQ-031 Shared package rename_pkg SHALL hold PREG_W, AREG_W, ZERO_REG defaults and a lane-slice helper.
REQ-032 One sub-module rename_dep_sel (combinational youngest-older-producer priority select for one source of one lane) SHALL be instantiated 3x per lane, lanes 1..WIDTH-1.

Verification
REQ-033 Lane1 rs1=r3, lane0 rd=r3 wr=1 new=0x45 -> lane1 rs1_phys_o=0x45 one cycle after acceptance.
REQ-034 Lanes 0,1,2 all rd=r7 wr=1, new tags 0x10/0x11/0x12, lane3 rs2=r7 -> lane3 rs2_phys_o=0x12, lane2 oldrd_phys_o=0x11, lane1 oldrd_phys_o=0x10.
REQ-035 Lane0 rd=r31 wr=1, lane2 rs1=r31, RAT rs1=0x1F -> lane2 rs1_phys_o=0x1F (zero register never bypassed).
REQ-036 Lane0 rd=r4 lane_valid=0, lane1 rs1=r4, RAT 0x22 -> lane1 rs1_phys_o=0x22.
REQ-037 out_ready_i=0 for 3 cycles with group held -> outputs stable, in_ready_o=0; out_ready_i=1 with new group -> back-to-back transfer, out_valid_o stays 1.
REQ-038 flush_i with out_valid_o=1 and in_valid_i=1 -> next cycle out_valid_o=0, lane_valid_o=0, offered group dropped; rst_i mid-stall -> out_valid_o=0, in_ready_o=1.
